riscv_multicycle_controller: RTL and testbench

Moore/Mealy FSM that sequences the RV32I multi-cycle datapath: one shared ALU and one unified instruction/data memory, reused across cycles. It decodes the instruction register fields, steps through fetch, decode, execute, memory and write-back states, and drives every datapath enable and mux select. It stalls on a memory-ready handshake and flags illegal encodings.

---
 rtl/riscv_pkg.sv | 76 +++++++
 rtl/riscv_multicycle_controller_alu_decoder.sv | 53 +++++
 rtl/riscv_multicycle_controller.sv | 191 +++++++++++++++++++
 tb/tb_riscv_multicycle_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the RV32I multi-cycle controller.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Contents: FSM state enum, opcode constants, datapath select encodings, ImmSrc helper.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Which ALU mapping the current state wants.
  typedef enum logic [1:0] {
    ACLS_ADD = 2'd0,
    ACLS_SUB = 2'd1,
    ACLS_R   = 2'd2,
    ACLS_I   = 2'd3
  } alu_class_t;

  // Immediate format is a pure function of the opcode; R-type and unknown ops fall back to I.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_src_of = IMM_S;
      OP_BRANCH: imm_src_of = IMM_B;
      OP_JAL:    imm_src_of = IMM_J;
      OP_LUI:    imm_src_of = IMM_U;
      default:   imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_multicycle_controller_alu_decoder.sv
// alu_decoder: maps opcode/funct fields and the state's ALU class to ALUControl, flags bad funct fields.
// Latency: combinational, 0 cycles. Backpressure: none.
// Ports: op_i/func3_i/func7_i instruction fields, alu_class_i; alu_control_o, illegal_funct_o.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] func3_i,
  input  logic [6:0] func7_i,
  input  alu_class_t alu_class_i,
  output logic [2:0] alu_control_o,
  output logic       illegal_funct_o
);

  logic alu_f3_ok;

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_class_i)
      ACLS_SUB: alu_control_o = ALU_SUB;
      ACLS_R, ACLS_I: begin
        case (func3_i)
          // Only R-type honours func7[5]; for addi that bit belongs to the immediate.
          3'b000:  alu_control_o = (alu_class_i == ACLS_R && func7_i[5]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

  assign alu_f3_ok = (func3_i == 3'b000) || (func3_i == 3'b010) ||
                     (func3_i == 3'b110) || (func3_i == 3'b111);

  // Legality is judged on the raw fields, independent of state, so DECODE can use it.
  always_comb begin
    illegal_funct_o = 1'b0;
    case (op_i)
      OP_RTYPE:           illegal_funct_o = !alu_f3_ok ||
                                            !((func7_i == 7'b0000000) || (func7_i == 7'b0100000));
      OP_ITYPE:           illegal_funct_o = !alu_f3_ok;
      OP_LOAD, OP_STORE:  illegal_funct_o = (func3_i != 3'b010);
      OP_JALR:            illegal_funct_o = (func3_i != 3'b000);
      OP_BRANCH:          illegal_funct_o = !((func3_i == 3'b000) || (func3_i == 3'b001) ||
                                              (func3_i == 3'b100) || (func3_i == 3'b101));
      default:            illegal_funct_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// riscv_multicycle_controller: FSM sequencing the RV32I multi-cycle datapath (shared ALU, unified memory).
// Latency: 3-5 cycles per instruction; +1 cycle per memReady-low cycle in FETCH/MEMREAD/MEMWRITE.
// Backpressure: holds state and all outputs while memReady is low in a memory state.
// Ports: clk, rst; op/func3/func7, zero, lt, memReady in; write enables, mux selects, ALUControl,
//        ImmSrc, instrDone and illegal pulses out.
module riscv_multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       lt,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       instrDone,
  output logic       illegal
);

  state_t     state_q, state_d;
  alu_class_t alu_class;
  logic       illegal_funct;
  logic       known_op;
  logic       taken;
  logic       pc_write_d, ir_write_d, mem_write_d, reg_write_d, done_d, illegal_d;

  alu_decoder u_alu_decoder (
    .op_i            (op),
    .func3_i         (func3),
    .func7_i         (func7),
    .alu_class_i     (alu_class),
    .alu_control_o   (ALUControl),
    .illegal_funct_o (illegal_funct)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  assign known_op = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
                    (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL) ||
                    (op == OP_JALR) || (op == OP_LUI);

  always_comb begin
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      default: taken = 1'b0;
    endcase
  end

  assign ImmSrc = imm_src_of(op);

  always_comb begin
    state_d     = state_q;
    alu_class   = ACLS_ADD;
    AdrSrc      = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    ResultSrc   = RES_ALUOUT;
    pc_write_d  = 1'b0;
    ir_write_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = 1'b0;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALU;
        ir_write_d = memReady;
        pc_write_d = memReady;
        if (memReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute PC+imm into ALUOut for branch/jal.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (!known_op || illegal_funct) begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE:          state_d = S_EXECR;
            OP_ITYPE:          state_d = S_EXECI;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR1;
            default:           state_d = S_LUI;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = RES_MEM;
        reg_write_d = 1'b1;
        done_d      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_d = 1'b1;
        if (memReady) begin
          done_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA   = SRCA_RS1;
        alu_class = ACLS_R;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        alu_class = ACLS_I;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_d = 1'b1;
        done_d      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        // Target already sits in ALUOut; the ALU here only compares rs1/rs2.
        ALUSrcA    = SRCA_RS1;
        alu_class  = ACLS_SUB;
        pc_write_d = taken;
        done_d     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC <= ALUOut (target) while the ALU forms OldPC+4 for the link write.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_write_d = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR1: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = S_JALR2;
      end
      S_JALR2: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_write_d = 1'b1;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc   = RES_IMM;
        reg_write_d = 1'b1;
        done_d      = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset must suppress every side effect immediately, not only from the next edge.
  assign PCWrite   = pc_write_d  & ~rst;
  assign IRWrite   = ir_write_d  & ~rst;
  assign MemWrite  = mem_write_d & ~rst;
  assign RegWrite  = reg_write_d & ~rst;
  assign instrDone = done_d      & ~rst;
  assign illegal   = illegal_d   & ~rst;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
module tb_riscv_multicycle_controller;

  typedef struct packed {
    logic       pcw, irw, mw, rw, adr;
    logic [1:0] a, b, res;
    logic [2:0] alu, imm;
    logic       done, ill;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] func3 = 3'b000;
  logic [6:0] func7 = 7'b0000000;
  logic       zero = 1'b0;
  logic       lt = 1'b0;
  logic       memReady = 1'b1;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, instrDone, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUControl, ImmSrc;

  out_t  act;
  out_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  riscv_multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .zero(zero), .lt(lt), .memReady(memReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instrDone(instrDone), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB,
                ResultSrc, ALUControl, ImmSrc, instrDone, illegal};

  // Monitor: every cycle the controller presents a full output vector; compare at mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      out_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %05h expected %05h", nm, act, e);
      end
    end
  end

  function automatic out_t E(input logic pcw, irw, mw, rw, adr,
                             input logic [1:0] a, b, res,
                             input logic [2:0] alu, imm,
                             input logic done, ill);
    E = '{pcw, irw, mw, rw, adr, a, b, res, alu, imm, done, ill};
  endfunction

  function automatic out_t FE(input logic [2:0] imm, input logic mr);
    FE = E(mr, mr, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, imm, 0, 0);
  endfunction

  function automatic out_t DE(input logic [2:0] imm);
    DE = E(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, imm, 0, 0);
  endfunction

  function automatic out_t WB(input logic [2:0] imm);
    WB = E(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 0);
  endfunction

  task automatic ins(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    op = o; func3 = f3; func7 = f7;
  endtask

  // Drive one cycle's inputs and queue the output vector expected during that cycle.
  task automatic cyc(input logic mr, input out_t e, input string nm);
    memReady = mr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset: FETCH selects visible, all enables forced low even with memReady=1.
    cyc(1, E(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 0, 0), "reset0");
    cyc(1, E(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 0, 0), "reset1");
    rst = 1'b0;

    // add x3,x1,x2
    ins(7'b0110011, 3'b000, 7'b0000000);
    cyc(1, FE(3'b000, 1), "add_fetch");
    cyc(1, DE(3'b000), "add_decode");
    cyc(1, E(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0), "add_execr");
    cyc(1, WB(3'b000), "add_aluwb");

    // sub
    ins(7'b0110011, 3'b000, 7'b0100000);
    cyc(1, FE(3'b000, 1), "sub_fetch");
    cyc(1, DE(3'b000), "sub_decode");
    cyc(1, E(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001, 3'b000, 0, 0), "sub_execr");
    cyc(1, WB(3'b000), "sub_aluwb");

    // or (R-type f3 110)
    ins(7'b0110011, 3'b110, 7'b0000000);
    cyc(1, FE(3'b000, 1), "or_fetch");
    cyc(1, DE(3'b000), "or_decode");
    cyc(1, E(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b011, 3'b000, 0, 0), "or_execr");
    cyc(1, WB(3'b000), "or_aluwb");

    // slti; func7[5] set by the immediate must not matter
    ins(7'b0010011, 3'b010, 7'b0100000);
    cyc(1, FE(3'b000, 1), "slti_fetch");
    cyc(1, DE(3'b000), "slti_decode");
    cyc(1, E(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b101, 3'b000, 0, 0), "slti_execi");
    cyc(1, WB(3'b000), "slti_aluwb");

    // addi with func7[5]=1 stays add
    ins(7'b0010011, 3'b000, 7'b0100000);
    cyc(1, FE(3'b000, 1), "addi_fetch");
    cyc(1, DE(3'b000), "addi_decode");
    cyc(1, E(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 0, 0), "addi_execi");
    cyc(1, WB(3'b000), "addi_aluwb");

    // lw with two stall cycles in MEMREAD: 7 cycles
    ins(7'b0000011, 3'b010, 7'b0000000);
    cyc(1, FE(3'b000, 1), "lw_fetch");
    cyc(1, DE(3'b000), "lw_decode");
    cyc(1, E(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 0, 0), "lw_memadr");
    cyc(0, E(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0), "lw_memread_stall0");
    cyc(0, E(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0), "lw_memread_stall1");
    cyc(1, E(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0), "lw_memread");
    cyc(1, E(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000, 1, 0), "lw_memwb");

    // sw with a FETCH stall and a MEMWRITE stall
    ins(7'b0100011, 3'b010, 7'b0000000);
    cyc(0, FE(3'b001, 0), "sw_fetch_stall");
    cyc(1, FE(3'b001, 1), "sw_fetch");
    cyc(1, DE(3'b001), "sw_decode");
    cyc(1, E(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b001, 0, 0), "sw_memadr");
    cyc(0, E(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0, 0), "sw_memwrite_stall");
    cyc(1, E(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 1, 0), "sw_memwrite");

    // blt taken
    ins(7'b1100011, 3'b100, 7'b0000000);
    lt = 1'b1; zero = 1'b0;
    cyc(1, FE(3'b010, 1), "blt_fetch");
    cyc(1, DE(3'b010), "blt_decode");
    cyc(1, E(1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001, 3'b010, 1, 0), "blt_branch");

    // bge not taken with lt=1
    ins(7'b1100011, 3'b101, 7'b0000000);
    cyc(1, FE(3'b010, 1), "bge_fetch");
    cyc(1, DE(3'b010), "bge_decode");
    cyc(1, E(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001, 3'b010, 1, 0), "bge_branch");

    // bne taken with zero=0
    ins(7'b1100011, 3'b001, 7'b0000000);
    lt = 1'b0;
    cyc(1, FE(3'b010, 1), "bne_fetch");
    cyc(1, DE(3'b010), "bne_decode");
    cyc(1, E(1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001, 3'b010, 1, 0), "bne_branch");

    // jal
    ins(7'b1101111, 3'b000, 7'b0000000);
    cyc(1, FE(3'b011, 1), "jal_fetch");
    cyc(1, DE(3'b011), "jal_decode");
    cyc(1, E(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'b000, 3'b011, 0, 0), "jal_jal");
    cyc(1, WB(3'b011), "jal_aluwb");

    // jalr
    ins(7'b1100111, 3'b000, 7'b0000000);
    cyc(1, FE(3'b000, 1), "jalr_fetch");
    cyc(1, DE(3'b000), "jalr_decode");
    cyc(1, E(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 0, 0), "jalr_jalr1");
    cyc(1, E(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0), "jalr_jalr2");
    cyc(1, WB(3'b000), "jalr_aluwb");

    // lui
    ins(7'b0110111, 3'b000, 7'b0000000);
    cyc(1, FE(3'b100, 1), "lui_fetch");
    cyc(1, DE(3'b100), "lui_decode");
    cyc(1, E(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b11, 3'b000, 3'b100, 1, 0), "lui_lui");

    // Unknown opcode
    ins(7'b1111111, 3'b000, 7'b0000000);
    cyc(1, FE(3'b000, 1), "badop_fetch");
    cyc(1, E(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 3'b000, 0, 1), "badop_decode");

    // R-type with bad func7
    ins(7'b0110011, 3'b000, 7'b0000001);
    cyc(1, FE(3'b000, 1), "badf7_fetch");
    cyc(1, E(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 3'b000, 0, 1), "badf7_decode");

    // lw with func3 000
    ins(7'b0000011, 3'b000, 7'b0000000);
    cyc(1, FE(3'b000, 1), "badlw_fetch");
    cyc(1, E(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 3'b000, 0, 1), "badlw_decode");

    // jalr with func3 001
    ins(7'b1100111, 3'b001, 7'b0000000);
    cyc(1, FE(3'b000, 1), "badjalr_fetch");
    cyc(1, E(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 3'b000, 0, 1), "badjalr_decode");

    // Reset while MemWrite is held in MEMWRITE
    ins(7'b0100011, 3'b010, 7'b0000000);
    cyc(1, FE(3'b001, 1), "rstsw_fetch");
    cyc(1, DE(3'b001), "rstsw_decode");
    cyc(1, E(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b001, 0, 0), "rstsw_memadr");
    cyc(0, E(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0, 0), "rstsw_memwrite");
    rst = 1'b1;
    cyc(0, E(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b001, 0, 0), "rstsw_in_reset");
    rst = 1'b0;
    cyc(0, FE(3'b001, 0), "rstsw_after_release");
    cyc(1, FE(3'b001, 1), "rstsw_refetch");
    cyc(1, DE(3'b001), "rstsw_redecode");

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
